cv32e41s_rchk_sequencer: RTL

Tracks outstanding OBI transactions on one bus interface (instruction or data) and sequences response integrity checking. On each address-phase handshake it records whether integrity checking is required and whether the access is a write. On each response it drives the per-response enable to an internal `cv32e41s_rchk_check` and registers the resulting integrity and protocol alerts. It sits between the OBI response path and the core alert logic.

---
 rtl/cv32e41s_pkg.sv | 28 ++
 rtl/cv32e41s_rchk_check.sv | 36 +++
 rtl/cv32e41s_rchk_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the response integrity check path.
//   obi_inst_resp_t  : OBI response payload (rdata, err, rchk, integrity)
//   rchk_seq_entry_t : per-transaction record held by the rchk sequencer
//   RCHK_EN_*        : checker enable encodings {check err, check rdata}
package cv32e41s_pkg;

    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_RCHK_W = 5;
    localparam int unsigned RCHK_EN_W  = 2;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
        logic [OBI_RCHK_W-1:0] rchk;
        logic                  integrity;
    } obi_inst_resp_t;

    typedef struct packed {
        logic we;
        logic integ;
    } rchk_seq_entry_t;

    // Bit 1 enables the err check, bit 0 enables the rdata byte-parity check.
    localparam logic [RCHK_EN_W-1:0] RCHK_EN_NONE = 2'b00;
    localparam logic [RCHK_EN_W-1:0] RCHK_EN_ERR  = 2'b10;
    localparam logic [RCHK_EN_W-1:0] RCHK_EN_ALL  = 2'b11;

endpackage

// File: rtl/cv32e41s_rchk_check.sv
// Combinational response checksum checker.
//   resp_i   : OBI response (rdata, err, rchk)
//   enable_i : {check err, check rdata}
//   err_o    : mismatch between enabled fields and rchk (combinational)
// rchk[3:0] hold the even parity of each rdata byte, rchk[4] the parity of err.
module cv32e41s_rchk_check
    import cv32e41s_pkg::*;
#(
    parameter type RESP_TYPE = obi_inst_resp_t
) (
    input  RESP_TYPE               resp_i,
    input  logic [RCHK_EN_W-1:0]   enable_i,
    output logic                   err_o
);

    // Integrity flag is consumed by the sequencer, not by the checksum.
    logic unused_integrity;
    assign unused_integrity = resp_i.integrity;

    always_comb begin
        err_o = 1'b0;
        if (enable_i[0]) begin
            for (int i = 0; i < 4; i++) begin
                if ((^resp_i.rdata[8*i +: 8]) != resp_i.rchk[i]) begin
                    err_o = 1'b1;
                end
            end
        end
        if (enable_i[1]) begin
            if (resp_i.err != resp_i.rchk[4]) begin
                err_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv32e41s_rchk_sequencer.sv
// Tracks outstanding OBI transactions and sequences response integrity checks.
//   clk, rst_n        : clock, async active-low reset
//   obi_req_i/gnt_i   : address-phase handshake; accepted when both high
//   obi_we_i          : write enable of the accepted transaction
//   integrity_req_i   : accepted transaction requires integrity checking
//   obi_rvalid_i      : response valid, resp_i its payload
//   req_allowed_o     : outstanding count below DEPTH
//   outstanding_o     : outstanding count
//   integrity_err_o   : one-cycle alert, one cycle after an offending response
//   protocol_err_o    : one-cycle alert on handshake misuse
//   err_sticky_o      : sticky OR of all alerts, cleared by clear_i
module cv32e41s_rchk_sequencer
    import cv32e41s_pkg::*;
#(
    parameter type         RESP_TYPE = obi_inst_resp_t,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         obi_req_i,
    input  logic                         obi_gnt_i,
    input  logic                         obi_we_i,
    input  logic                         integrity_req_i,
    input  logic                         obi_rvalid_i,
    input  RESP_TYPE                     resp_i,
    output logic                         req_allowed_o,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         integrity_err_o,
    output logic                         protocol_err_o,
    output logic                         err_sticky_o,
    input  logic                         clear_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    rchk_seq_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_allowed_q, req_allowed_d;
    logic                   integrity_err_q, integrity_err_d;
    logic                   protocol_err_q, protocol_err_d;
    logic                   err_sticky_q, err_sticky_d;

    logic                   accept_c;
    logic                   full_c;
    logic                   empty_c;
    logic                   push_c;
    logic                   pop_c;
    rchk_seq_entry_t        head_c;
    rchk_seq_entry_t        new_entry_c;
    logic [RCHK_EN_W-1:0]   chk_en_c;
    logic                   chk_err_c;

    assign accept_c    = obi_req_i && obi_gnt_i;
    assign full_c      = (cnt_q == CNT_FULL);
    assign empty_c     = (cnt_q == '0);
    assign push_c      = accept_c && !full_c;
    assign pop_c       = obi_rvalid_i && !empty_c;
    assign head_c      = fifo_q[rptr_q];
    assign new_entry_c = '{we: obi_we_i, integ: integrity_req_i};

    // Head entry selects which response fields are covered by rchk.
    always_comb begin
        chk_en_c = RCHK_EN_NONE;
        if (pop_c && head_c.integ) begin
            chk_en_c = head_c.we ? RCHK_EN_ERR : RCHK_EN_ALL;
        end
    end

    cv32e41s_rchk_check #(
        .RESP_TYPE (RESP_TYPE)
    ) u_rchk_check (
        .resp_i   (resp_i),
        .enable_i (chk_en_c),
        .err_o    (chk_err_c)
    );

    // Next-state for pointers, count and alert registers.
    always_comb begin
        rptr_d          = rptr_q;
        wptr_d          = wptr_q;
        cnt_d           = cnt_q;
        integrity_err_d = 1'b0;
        protocol_err_d  = 1'b0;
        err_sticky_d    = err_sticky_q;

        if (push_c) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Missing integrity on a checked entry is as bad as a checksum mismatch.
        integrity_err_d = pop_c && (chk_err_c || (head_c.integ && !resp_i.integrity));
        protocol_err_d  = (accept_c && full_c) || (obi_rvalid_i && empty_c);

        // A new alert outranks a simultaneous clear.
        if (clear_i) begin
            err_sticky_d = 1'b0;
        end
        if (integrity_err_d || protocol_err_d) begin
            err_sticky_d = 1'b1;
        end
    end

    assign req_allowed_d = (cnt_d < CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q          <= '0;
            wptr_q          <= '0;
            cnt_q           <= '0;
            req_allowed_q   <= 1'b1;
            integrity_err_q <= 1'b0;
            protocol_err_q  <= 1'b0;
            err_sticky_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rptr_q          <= rptr_d;
            wptr_q          <= wptr_d;
            cnt_q           <= cnt_d;
            req_allowed_q   <= req_allowed_d;
            integrity_err_q <= integrity_err_d;
            protocol_err_q  <= protocol_err_d;
            err_sticky_q    <= err_sticky_d;
            if (push_c) begin
                fifo_q[wptr_q] <= new_entry_c;
            end
        end
    end

    assign req_allowed_o   = req_allowed_q;
    assign outstanding_o   = cnt_q;
    assign integrity_err_o = integrity_err_q;
    assign protocol_err_o  = protocol_err_q;
    assign err_sticky_o    = err_sticky_q;

endmodule
